// File: rtl/sram_model_pkg.sv
// Shared types and constants for the parametrised external SRAM model.
package sram_model_pkg;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    localparam int READ_LAT_MIN = 0;
    localparam int READ_LAT_MAX = 4;

    function automatic int lanes_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read delay line of {valid, lane mask, data}; READ_LAT=0 is a straight bypass.
module sram_rd_pipe #(
    parameter int READ_LAT = 0,
    parameter int DATA_W   = 16,
    parameter int LANES    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_vld,
    input  logic [LANES-1:0]  in_mask,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [LANES-1:0]  out_mask,
    output logic [DATA_W-1:0] out_data
);

    if (READ_LAT == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, reset_n};
        assign out_vld  = in_vld;
        assign out_mask = in_mask;
        assign out_data = in_data;
    end else begin : g_pipe
        logic [READ_LAT:1]             vld_pipe;
        logic [READ_LAT:1][LANES-1:0]  mask_pipe;
        logic [READ_LAT:1][DATA_W-1:0] data_pipe;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_pipe  <= '0;
                mask_pipe <= '0;
                data_pipe <= '0;
            end else begin
                vld_pipe[1]  <= in_vld;
                mask_pipe[1] <= in_mask;
                data_pipe[1] <= in_data;
                for (int s = 2; s <= READ_LAT; s++) begin
                    vld_pipe[s]  <= vld_pipe[s-1];
                    mask_pipe[s] <= mask_pipe[s-1];
                    data_pipe[s] <= data_pipe[s-1];
                end
            end
        end

        assign out_vld  = vld_pipe[READ_LAT];
        assign out_mask = mask_pipe[READ_LAT];
        assign out_data = data_pipe[READ_LAT];
    end

endmodule

// File: rtl/sram_model_param.sv
// Behavioural external SRAM: byte lanes, registered read latency, optional
// post-reset clear sweep gating a ready flag.
module sram_model_param
    import sram_model_pkg::*;
#(
    parameter int              ADDR_W         = 18,
    parameter int              DATA_W         = 16,
    parameter int              READ_LAT       = 0,
    parameter int              CLEAR_ON_RESET = 0,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0,
    localparam int             LANES          = lanes_of(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] i_sram_addr,
    input  logic              i_sram_ce_n,
    input  logic              i_sram_we_n,
    input  logic              i_sram_oe_n,
    input  logic [LANES-1:0]  i_sram_be_n,
    inout  wire  [DATA_W-1:0] io_sram_dq,
    output logic              o_sram_ready
);

    if (DATA_W % 8 != 0) begin : g_chk_data_w
        $fatal(1, "sram_model_param: DATA_W must be a multiple of 8");
    end
    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_chk_lat
        $fatal(1, "sram_model_param: READ_LAT out of range 0..4");
    end

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              sweep_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (sweep_en) sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        sweep_en  = 1'b0;
        case (state)
            INIT: begin
                if (CLEAR_ON_RESET == 0) begin
                    state_nxt = READY;
                end else begin
                    sweep_en = 1'b1;
                    if (sweep_cnt == '1) state_nxt = READY;
                end
            end
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    assign o_sram_ready = (state == READY);

    logic wr_acc, rd_iss;
    assign wr_acc = o_sram_ready & ~i_sram_ce_n & ~i_sram_we_n & i_sram_oe_n;
    assign rd_iss = o_sram_ready & ~i_sram_ce_n & i_sram_we_n;

    // Held in reset the sweep may rewrite address 0, which the sweep covers
    // first anyway once reset lifts, so memory contents are unaffected.
    always_ff @(posedge clk) begin
        if (sweep_en) begin
            mem[sweep_cnt] <= INIT_VALUE;
        end else if (wr_acc) begin
            for (int k = 0; k < LANES; k++) begin
                if (!i_sram_be_n[k]) mem[i_sram_addr][8*k +: 8] <= io_sram_dq[8*k +: 8];
            end
        end
    end

    logic              rd_vld;
    logic [LANES-1:0]  rd_mask;
    logic [DATA_W-1:0] rd_data;

    sram_rd_pipe #(
        .READ_LAT (READ_LAT),
        .DATA_W   (DATA_W),
        .LANES    (LANES)
    ) u_rd_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_vld   (rd_iss),
        .in_mask  (~i_sram_be_n),
        .in_data  (mem[i_sram_addr]),
        .out_vld  (rd_vld),
        .out_mask (rd_mask),
        .out_data (rd_data)
    );

    // Output data is dropped, not held, if oe_n/we_n block its single cycle.
    logic drv_en;
    assign drv_en = rd_vld & ~i_sram_oe_n & i_sram_we_n;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign io_sram_dq[8*k +: 8] = (drv_en && rd_mask[k]) ? rd_data[8*k +: 8] : 8'bz;
    end

endmodule

// File: tb/tb_sram_model_param.sv
// Directed bench: three model configurations share one control bus, each with
// its own data bus. An undriven lane reads as z (or 0 on two-state simulators).
module tb_sram_model_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  addr = '0;
    logic        ce_n = 1'b1, we_n = 1'b1, oe_n = 1'b1;
    logic [3:0]  be_n = '1;
    logic [31:0] wdata = '0;
    logic        wr_en = 1'b0;
    logic        rdy_a, rdy_b, rdy_c;
    wire  [15:0] dq_a;
    wire  [31:0] dq_b;
    wire  [15:0] dq_c;

    assign dq_a = wr_en ? wdata[15:0] : 'z;
    assign dq_b = wr_en ? wdata       : 'z;
    assign dq_c = wr_en ? wdata[15:0] : 'z;

    always #5 clk = ~clk;

    sram_model_param #(.ADDR_W(4), .DATA_W(16), .READ_LAT(2), .CLEAR_ON_RESET(1),
                       .INIT_VALUE(16'hA5A5)) u_a (
        .clk(clk), .reset_n(rst_n), .i_sram_addr(addr), .i_sram_ce_n(ce_n),
        .i_sram_we_n(we_n), .i_sram_oe_n(oe_n), .i_sram_be_n(be_n[1:0]),
        .io_sram_dq(dq_a), .o_sram_ready(rdy_a));

    sram_model_param #(.ADDR_W(4), .DATA_W(32), .READ_LAT(1), .CLEAR_ON_RESET(0),
                       .INIT_VALUE(32'h0)) u_b (
        .clk(clk), .reset_n(rst_n), .i_sram_addr(addr), .i_sram_ce_n(ce_n),
        .i_sram_we_n(we_n), .i_sram_oe_n(oe_n), .i_sram_be_n(be_n),
        .io_sram_dq(dq_b), .o_sram_ready(rdy_b));

    sram_model_param #(.ADDR_W(4), .DATA_W(16), .READ_LAT(0), .CLEAR_ON_RESET(0),
                       .INIT_VALUE(16'h0)) u_c (
        .clk(clk), .reset_n(rst_n), .i_sram_addr(addr), .i_sram_ce_n(ce_n),
        .i_sram_we_n(we_n), .i_sram_oe_n(oe_n), .i_sram_be_n(be_n[1:0]),
        .io_sram_dq(dq_c), .o_sram_ready(rdy_c));

    int errs = 0;
    int checks = 0;

    task automatic chk_bus(input string nm, input logic [31:0] act, input int nl,
                           input logic [3:0] drv, input logic [31:0] exp);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < nl; k++) begin
            logic [7:0] a;
            a = act[8*k +: 8];
            if (drv[k]) ok = ok && (a === exp[8*k +: 8]);
            else        ok = ok && ((a === 8'hzz) || (a === 8'h00));
        end
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %h, want %h on driven lanes %b (others z)", nm, act, exp, drv);
        end
    endtask

    task automatic chk_val(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; be_n = '1; wr_en = 1'b0;
    endtask

    task automatic do_wr(input logic [3:0] a, input logic [3:0] be, input logic oe,
                         input logic [31:0] d);
        @(posedge clk); #1;
        addr = a; be_n = be; ce_n = 1'b0; we_n = 1'b0; oe_n = oe; wdata = d; wr_en = 1'b1;
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [3:0]  be_n;
        logic        oe_n;    // oe_n in the request cycle
        logic        oe_out;  // oe_n in the following (LAT=1 output) cycle
        logic [31:0] data;
        logic [31:0] exp_b;
        logic [15:0] exp_c;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int cnt;
        logic [15:0] e16;

        vecs[0]  = '{1'b1, 4'd5, 4'b0000, 1'b1, 1'b1, 32'h11223344, 32'h0,        16'h0};
        vecs[1]  = '{1'b0, 4'd5, 4'b0000, 1'b0, 1'b0, 32'h0,        32'h11223344, 16'h3344};
        vecs[2]  = '{1'b1, 4'd5, 4'b1010, 1'b1, 1'b1, 32'hAABBCCDD, 32'h0,        16'h0};
        vecs[3]  = '{1'b0, 4'd5, 4'b0000, 1'b0, 1'b0, 32'h0,        32'h11BB33DD, 16'h33DD};
        vecs[4]  = '{1'b0, 4'd5, 4'b0110, 1'b0, 1'b0, 32'h0,        32'h11BB33DD, 16'h33DD};
        vecs[5]  = '{1'b1, 4'd7, 4'b0000, 1'b1, 1'b1, 32'h0A0B0C0D, 32'h0,        16'h0};
        vecs[6]  = '{1'b1, 4'd7, 4'b0000, 1'b0, 1'b1, 32'h21222324, 32'h0,        16'h0};
        vecs[7]  = '{1'b0, 4'd7, 4'b0000, 1'b0, 1'b0, 32'h0,        32'h0A0B0C0D, 16'h0C0D};
        vecs[8]  = '{1'b0, 4'd7, 4'b0000, 1'b0, 1'b1, 32'h0,        32'h0A0B0C0D, 16'h0C0D};
        vecs[9]  = '{1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 32'h0,        32'h56781234, 16'h1234};
        vecs[10] = '{1'b0, 4'd7, 4'b0000, 1'b1, 1'b0, 32'h0,        32'h0A0B0C0D, 16'h0C0D};

        // Reset state
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_val("rst_ready_a", int'(rdy_a), 0);
        chk_val("rst_ready_b", int'(rdy_b), 0);
        chk_val("rst_ready_c", int'(rdy_c), 0);
        chk_bus("rst_dq_a", {16'h0, dq_a}, 2, 4'b0000, 32'h0);
        chk_bus("rst_dq_b", dq_b,          4, 4'b0000, 32'h0);
        chk_bus("rst_dq_c", {16'h0, dq_c}, 2, 4'b0000, 32'h0);

        // Sweep aborted by reset at address 9
        rst_n = 1'b1;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_val("abort_ready_a", int'(rdy_a), 0);
        chk_val("abort_ready_b", int'(rdy_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Restarted sweep, with requests injected while u_a is still in INIT
        cnt = 0;
        while (cnt < 40 && !rdy_a) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) chk_val("noclear_ready", int'(rdy_b && rdy_c), 1);
            if (cnt == 5) begin
                addr = 4'd0; be_n = 4'b0000; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
                wdata = 32'h56781234; wr_en = 1'b1;
            end
            if (cnt == 6) begin
                wr_en = 1'b0; addr = 4'd0; be_n = 4'b0000; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
            end
            if (cnt == 7) ce_n = 1'b1;
            if (cnt == 8) begin
                chk_bus("init_rd_dq_a", {16'h0, dq_a}, 2, 4'b0000, 32'h0);
                chk_val("init_ready_a", int'(rdy_a), 0);
                idle();
            end
        end
        chk_val("sweep_cycles", cnt, 16);
        idle();

        // Every address of u_a holds the fill value; LAT=2 back-to-back reads
        for (int c = 0; c < 19; c++) begin
            @(posedge clk); #1;
            if (c < 16) begin
                addr = c[3:0]; be_n = 4'b0000; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
            end else begin
                ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b0;
            end
            @(negedge clk);
            chk_bus($sformatf("sweep_rd_c%0d", c), {16'h0, dq_a}, 2,
                    (c >= 2 && c <= 17) ? 4'b0011 : 4'b0000, 32'h0000A5A5);
        end
        idle();

        // Lane-enable / latency vectors on u_b (LAT=1) and u_c (LAT=0)
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) begin
                do_wr(vecs[i].addr, vecs[i].be_n, vecs[i].oe_n, vecs[i].data);
            end else begin
                @(posedge clk); #1;
                wr_en = 1'b0; addr = vecs[i].addr; be_n = vecs[i].be_n;
                ce_n = 1'b0; we_n = 1'b1; oe_n = vecs[i].oe_n;
                @(negedge clk);
                chk_bus($sformatf("vec%0d_c", i), {16'h0, dq_c}, 2,
                        vecs[i].oe_n ? 4'b0000 : {2'b00, ~vecs[i].be_n[1:0]},
                        {16'h0, vecs[i].exp_c});
                @(posedge clk); #1;
                ce_n = 1'b1; we_n = 1'b1; oe_n = vecs[i].oe_out; be_n = '1;
                @(negedge clk);
                chk_bus($sformatf("vec%0d_b", i), dq_b, 4,
                        vecs[i].oe_out ? 4'b0000 : ~vecs[i].be_n, vecs[i].exp_b);
            end
        end
        idle();

        // LAT=2 pipelining in issue order, then release
        do_wr(4'd1, 4'b0000, 1'b1, 32'h00001010);
        do_wr(4'd2, 4'b0000, 1'b1, 32'h00002020);
        do_wr(4'd3, 4'b0000, 1'b1, 32'h00003030);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            wr_en = 1'b0; we_n = 1'b1; oe_n = 1'b0; be_n = 4'b0000;
            if (c < 3) begin
                addr = 4'(c + 1); ce_n = 1'b0;
            end else begin
                ce_n = 1'b1;
            end
            @(negedge clk);
            case (c)
                2:       e16 = 16'h1010;
                3:       e16 = 16'h2020;
                4:       e16 = 16'h3030;
                default: e16 = 16'h0000;
            endcase
            chk_bus($sformatf("lat2_c%0d", c), {16'h0, dq_a}, 2,
                    (c >= 2 && c <= 4) ? 4'b0011 : 4'b0000, {16'h0, e16});
        end
        idle();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
